// File: rtl/data_memory_ctrl.sv
// Data memory for the MIPS MEM stage: byte/half/word access with byte lanes,
// signed/unsigned load extension, error flagging and an optional post-reset clear sweep.
module data_memory_ctrl #(
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             clear_we;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             out_of_range;
    logic             misaligned;
    logic             err;
    logic             accept;
    logic             store_we;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;

    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    // State register; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one word per cycle, then sit in IDLE serving requests.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        unique case (state_q)
            StClear: begin
                clear_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign init_done = (state_q == StIdle);

    // Address decode and error classification.
    always_comb begin
        idx          = req_addr[IDX_W+1:2];
        lane         = req_addr[1:0];
        out_of_range = (req_addr >> (IDX_W + 2)) != '0;
        misaligned   = ((req_size == 2'b01) && lane[0]) ||
                       ((req_size == 2'b10) && (lane != 2'b00));
        err          = out_of_range || misaligned || (req_size == 2'b11);
        accept       = req_valid && req_ready;
        store_we     = accept && req_we && !err;
    end

    // Lane enables and replicated write data so each lane sees its own bits.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        unique case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
            2'b11: begin
                wr_be   = 4'b0000;
                wr_data = req_wdata;
            end
        endcase
    end

    // RAM array: clear sweep or lane-masked store; nothing written while in reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clear_we) begin
                mem[cnt_q] <= '0;
            end else if (store_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_be[i]) begin
                        mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Load lane selection and extension.
    always_comb begin
        rd_word  = mem[idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = '0;
        unique case (req_size)
            2'b00:   load_val = req_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = req_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            2'b10:   load_val = rd_word;
            2'b11:   load_val = '0;
        endcase
    end

    // Response register: one pulse per accepted request, dropped by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= (accept && !err && !req_we) ? load_val : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed cases followed by random traffic
// compared against a byte-addressed reference memory.
module tb_data_memory_ctrl;

    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [NBYTES];

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .init_done(init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference: little-endian byte memory, access size 1/2/4 bytes.
    function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output bit err, output logic [31:0] rdata);
        int n;
        n     = 1 << size;
        err   = (addr >= NBYTES) || (size == 2'b11) || ((addr % n) != 0);
        rdata = '0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[addr + k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) rdata[8*k +: 8] = ref_mem[addr + k];
                if (!uns && n < 4 && rdata[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * n));
            end
        end
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    endtask

    // Drive one request (valid left high) and check the response after the accepting edge.
    task automatic req(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        bit          e;
        logic [31:0] r;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        model(we, size, uns, addr, wdata, e, r);
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " err"}, 32'(rsp_err), 32'(e));
        chk({tag, " rdata"}, rsp_rdata, r);
    endtask

    // Count edges from reset release until req_ready rises.
    task automatic wait_sweep(input string tag);
        int cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == DEPTH - 1) chk({tag, " init_done mid-sweep"}, 32'(init_done), 32'd0);
        end
        chk({tag, " sweep cycles"}, 32'(cyc), 32'(DEPTH));
        chk({tag, " init_done"}, 32'(init_done), 32'd1);
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        wait_sweep("t1");
        req(1'b0, 2'b10, 1'b0, 32'h0FC, 32'h0, "t1 lw 0xFC");
        chk("t1 lw 0xFC value", rsp_rdata, 32'h0000_0000);

        // Loads with extension
        req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF, "t2 sw");
        req(1'b0, 2'b00, 1'b0, 32'h011, 32'h0, "t2 lb");
        chk("t2 lb value", rsp_rdata, 32'hFFFF_FFBE);
        req(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, "t2 lbu");
        chk("t2 lbu value", rsp_rdata, 32'h0000_00DE);
        req(1'b0, 2'b01, 1'b0, 32'h012, 32'h0, "t2 lh");
        chk("t2 lh value", rsp_rdata, 32'hFFFF_DEAD);
        req(1'b0, 2'b01, 1'b1, 32'h010, 32'h0, "t2 lhu");
        chk("t2 lhu value", rsp_rdata, 32'h0000_BEEF);

        // Partial stores
        req(1'b1, 2'b00, 1'b0, 32'h012, 32'h0000_005A, "t3 sb");
        req(1'b1, 2'b01, 1'b0, 32'h010, 32'h0000_1234, "t3 sh");
        req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, "t3 lw");
        chk("t3 lw value", rsp_rdata, 32'hDE5A_1234);

        // Errors
        req(1'b1, 2'b10, 1'b0, 32'h00E, 32'h1111_1111, "t4 sw misaligned");
        chk("t4 sw err", 32'(rsp_err), 32'd1);
        req(1'b0, 2'b10, 1'b0, 32'h00C, 32'h0, "t4 lw 0x0C");
        chk("t4 lw 0x0C value", rsp_rdata, 32'h0);
        req(1'b0, 2'b01, 1'b0, 32'h011, 32'h0, "t4 lh odd");
        chk("t4 lh odd err", 32'(rsp_err), 32'd1);
        req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "t4 lw oor");
        chk("t4 lw oor err", 32'(rsp_err), 32'd1);
        req(1'b0, 2'b11, 1'b0, 32'h004, 32'h0, "t4 size11");
        chk("t4 size11 err", 32'(rsp_err), 32'd1);

        // Back-to-back with valid held
        req(1'b1, 2'b10, 1'b0, 32'h020, 32'h1234_5678, "t5 sw");
        req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, "t5 lw");
        chk("t5 lw value", rsp_rdata, 32'h1234_5678);
        req(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, "t5 sw0");
        req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, "t5 lw0");
        chk("t5 lw0 value", rsp_rdata, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 idle rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-sweep restarts the full sweep
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6 init_done at cycle 10", 32'(init_done), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 init_done in reset", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        wait_sweep("t6 restart");

        // Reset coinciding with a load drops the response; sweep clears memory
        req(1'b1, 2'b10, 1'b0, 32'h020, 32'hCAFE_F00D, "t6 sw");
        req_we   = 1'b0;
        req_addr = 32'h020;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 dropped rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6 dropped rsp_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 still no rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        wait_sweep("t6 after drop");
        req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, "t6 lw after clear");
        chk("t6 lw after clear value", rsp_rdata, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("rand idle rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                logic [31:0] a;
                a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
                req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    a, $urandom, "rand");
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
